// File: rtl/uart_loader_pkg.sv
// ============================================================================
// Module   : uart_loader_pkg
// Brief    : Shared state encoding and frame constants for the UART loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_SYNC = 3'd1,
        ST_CMD  = 3'd2,
        ST_ADDR = 3'd3,
        ST_DATA = 3'd4,
        ST_MEM  = 3'd5,
        ST_RESP = 3'd6
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  CMD_WR    = 8'h01;
    localparam logic [7:0]  CMD_RD    = 8'h02;
    localparam logic [7:0]  CMD_GO    = 8'h03;
    localparam logic [7:0]  ACK       = 8'h06;
    localparam logic [7:0]  NAK       = 8'h15;
    localparam logic [31:0] RX_EMPTY  = 32'hFFFF_FFFF;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD) || (cmd == CMD_GO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_loader_tx.sv
// ============================================================================
// Module   : uart_loader_tx
// Brief    : One-byte send handshake against the simpleuart TX data register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_loader_tx (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_tx_wait,
    output logic        o_tx_we,
    output logic [31:0] o_tx_di,
    output logic        o_done
);

    logic       r_we;
    logic [7:0] r_byte;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_we   <= 1'b0;
            r_byte <= 8'h00;
        end else if (r_we && !i_tx_wait) begin
            r_we <= 1'b0;
        end else if (i_start && !r_we) begin
            r_we   <= 1'b1;
            r_byte <= i_byte;
        end
    end

    assign o_tx_we = r_we;
    assign o_tx_di = {24'h0, r_byte};
    // Done marks the accepting cycle so the caller can react on the same edge.
    assign o_done  = r_we && !i_tx_wait;

endmodule

`default_nettype wire

// File: rtl/uart_loader.sv
// ============================================================================
// Module   : uart_loader
// Brief    : UART frame parser driving native-bus word reads/writes and CPU hold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter logic        HOLD_AT_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [3:0]  reg_div_we,
    output logic        reg_dat_we,
    output logic        reg_dat_re,
    output logic [31:0] reg_dat_di,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        cpu_hold,
    output logic [31:0] boot_addr
);

    localparam int unsigned          c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic [7:0]         r_cmd;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [1:0]         r_cnt;
    logic               r_final;
    logic               r_skip;
    logic               r_re;
    logic [3:0]         r_div_we;
    logic               r_mem_valid;
    logic [3:0]         r_mem_wstrb;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_cpu_hold;
    logic [31:0]        r_boot_addr;
    logic               r_tx_start;
    logic [7:0]         r_tx_byte;

    logic               w_rx_state;
    logic               w_tmo_state;
    logic               w_rx_hit;
    logic [7:0]         w_rx_byte;
    logic               w_tx_done;
    logic [1:0]         w_next_idx;

    assign w_rx_state  = (r_state == ST_SYNC) || (r_state == ST_CMD) ||
                         (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_tmo_state = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                         (r_state == ST_DATA);
    // The UART valid flag clears one edge after the consume pulse, so skip a cycle.
    assign w_rx_hit    = w_rx_state && !r_skip && (reg_dat_do != RX_EMPTY);
    assign w_rx_byte   = reg_dat_do[7:0];
    assign w_next_idx  = r_cnt + 2'd1;

    uart_loader_tx u_tx (
        .clk       (clk),
        .resetn    (resetn),
        .i_start   (r_tx_start),
        .i_byte    (r_tx_byte),
        .i_tx_wait (reg_dat_wait),
        .o_tx_we   (reg_dat_we),
        .o_tx_di   (reg_dat_di),
        .o_done    (w_tx_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_INIT;
            r_cmd       <= 8'h00;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_cnt       <= 2'd0;
            r_final     <= 1'b0;
            r_skip      <= 1'b0;
            r_re        <= 1'b0;
            r_div_we    <= 4'h0;
            r_mem_valid <= 1'b0;
            r_mem_wstrb <= 4'h0;
            r_tmo       <= '0;
            r_cpu_hold  <= HOLD_AT_RESET;
            r_boot_addr <= 32'h0;
            r_tx_start  <= 1'b0;
            r_tx_byte   <= 8'h00;
        end else begin
            r_div_we   <= 4'h0;
            r_tx_start <= 1'b0;
            r_re       <= w_rx_hit;
            r_skip     <= w_rx_hit;
            if (w_rx_hit || !w_tmo_state) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            case (r_state)
                ST_INIT: begin
                    r_div_we <= 4'hF;
                    r_state  <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (w_rx_hit && (w_rx_byte == SYNC_BYTE)) begin
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_rx_hit) begin
                        r_cmd <= w_rx_byte;
                        r_cnt <= 2'd0;
                        if (is_known_cmd(w_rx_byte)) begin
                            r_state <= ST_ADDR;
                        end else begin
                            r_tx_byte  <= NAK;
                            r_tx_start <= 1'b1;
                            r_final    <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rx_hit) begin
                        r_addr <= {w_rx_byte, r_addr[31:8]};
                        r_cnt  <= w_next_idx;
                        if (r_cnt == 2'd3) begin
                            if (r_cmd == CMD_WR) begin
                                r_state <= ST_DATA;
                            end else if (r_cmd == CMD_RD) begin
                                r_mem_valid <= 1'b1;
                                r_mem_wstrb <= 4'h0;
                                r_state     <= ST_MEM;
                            end else begin
                                r_tx_byte  <= ACK;
                                r_tx_start <= 1'b1;
                                r_final    <= 1'b1;
                                r_state    <= ST_RESP;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_rx_hit) begin
                        r_wdata <= {w_rx_byte, r_wdata[31:8]};
                        r_cnt   <= w_next_idx;
                        if (r_cnt == 2'd3) begin
                            r_mem_valid <= 1'b1;
                            r_mem_wstrb <= 4'hF;
                            r_state     <= ST_MEM;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'h0;
                        r_rdata     <= mem_rdata;
                        r_cnt       <= 2'd0;
                        r_tx_start  <= 1'b1;
                        if (r_cmd == CMD_RD) begin
                            r_tx_byte <= mem_rdata[7:0];
                            r_final   <= 1'b0;
                        end else begin
                            r_tx_byte <= ACK;
                            r_final   <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_tx_done) begin
                        if (r_final) begin
                            if (r_cmd == CMD_GO) begin
                                r_cpu_hold  <= 1'b0;
                                r_boot_addr <= r_addr;
                            end
                            r_state <= ST_SYNC;
                        end else begin
                            r_tx_start <= 1'b1;
                            if (r_cnt == 2'd3) begin
                                r_tx_byte <= ACK;
                                r_final   <= 1'b1;
                            end else begin
                                r_cnt     <= w_next_idx;
                                r_tx_byte <= r_rdata[8*w_next_idx +: 8];
                            end
                        end
                    end
                end
                default: r_state <= ST_INIT;
            endcase

            // An idle line mid-frame abandons the frame without a response.
            if (w_tmo_state && !w_rx_hit && (r_tmo == c_TMO_LAST)) begin
                r_state <= ST_SYNC;
            end
        end
    end

    assign reg_div_we = r_div_we;
    assign reg_dat_re = r_re;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign cpu_hold   = r_cpu_hold;
    assign boot_addr  = r_boot_addr;

endmodule

`default_nettype wire
